// File: rtl/popo_mem_pkg.sv
// Shared types for the cache/memory burst interface: response codes and the
// responder state encoding, used by both the cache initiator and memory responder.
package popo_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_RESP
  } mem_state_t;

endpackage

// File: rtl/burst_mem_responder_if.sv
// Cache/memory burst bus: request, write-beat, read-beat and write-response channels.
// master = cache initiator side, slave = memory responder side.
interface burst_mem_responder_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [DATA_ADDR_WIDTH-1:0] req_addr;
  logic                       wdata_valid;
  logic                       wdata_ready;
  logic [DATA_WIDTH-1:0]      wdata;
  logic                       wlast;
  logic                       rdata_valid;
  logic                       rdata_ready;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       rlast;
  logic                       bvalid;
  logic                       bready;
  logic [1:0]                 bresp;

  modport master (
    output req_valid, req_write, req_addr, wdata_valid, wdata, wlast, rdata_ready, bready,
    input  req_ready, wdata_ready, rdata_valid, rdata, rlast, bvalid, bresp
  );

  modport slave (
    input  req_valid, req_write, req_addr, wdata_valid, wdata, wlast, rdata_ready, bready,
    output req_ready, wdata_ready, rdata_valid, rdata, rlast, bvalid, bresp
  );
endinterface

// File: rtl/burst_mem_responder_array.sv
// Word storage for the burst responder: one synchronous write port and a
// combinational read port. Contents are deliberately not reset.
module burst_mem_array #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_WORDS  = 128,
  localparam int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_WIDTH-1:0] rword_o
);
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[widx_i] <= wdata_i;
  end

  assign rword_o = mem_q[ridx_i];
endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side burst responder: serves read and write-back bursts from an internal array.
// Define BURST_MEM_LATENCY_EN to insert RD_LATENCY wait cycles before the first read beat.
module burst_mem_responder
  import popo_mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int NUM_WORDS       = 128,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8,
  parameter int RD_LATENCY      = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  burst_mem_responder_if.slave bus
);
  localparam int IDX_W   = $clog2(NUM_WORDS);
  localparam int MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_BURST_LEN - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BURST_LEN - 1);

  mem_state_t            state_q, state_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  resp_t                 bresp_q, bresp_d;

  logic [IDX_W-1:0]      req_idx, ridx;
  logic [DATA_WIDTH-1:0] rword;
  logic                  we, load_rd;
  logic                  unused_addr;

  assign req_idx     = bus.req_addr[2 +: IDX_W];
  assign unused_addr = ^{bus.req_addr[1:0], bus.req_addr[DATA_ADDR_WIDTH-1:IDX_W+2]};

`ifdef BURST_MEM_LATENCY_EN
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  logic [LAT_W-1:0] lat_q, lat_d;
`else
  localparam int unused_rd_latency = RD_LATENCY;
`endif

  burst_mem_array #(.DATA_WIDTH(DATA_WIDTH), .NUM_WORDS(NUM_WORDS)) u_array (
    .clk_i  (sys_clk),
    .we_i   (we),
    .widx_i (ptr_q),
    .wdata_i(bus.wdata),
    .ridx_i (ridx),
    .rword_o(rword)
  );

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    bresp_d  = bresp_q;
    ridx     = ptr_q + IDX_W'(1);
    we       = 1'b0;
    load_rd  = 1'b0;
`ifdef BURST_MEM_LATENCY_EN
    lat_d    = lat_q;
`endif
    case (state_q)
      IDLE: begin
        ridx = req_idx;
        if (bus.req_valid) begin
          ptr_d  = req_idx;
          beat_d = '0;
          if (bus.req_write) begin
            state_d = WR_BURST;
          end else begin
`ifdef BURST_MEM_LATENCY_EN
            if (RD_LATENCY == 0) begin
              load_rd = 1'b1;
            end else begin
              lat_d   = LAT_W'(RD_LATENCY - 1);
              state_d = RD_WAIT;
            end
`else
            load_rd = 1'b1;
`endif
          end
        end
      end
`ifdef BURST_MEM_LATENCY_EN
      RD_WAIT: begin
        ridx = ptr_q;
        if (lat_q == '0) load_rd = 1'b1;
        else             lat_d   = lat_q - LAT_W'(1);
      end
`endif
      RD_BURST: begin
        // rvalid_q is always set here, so rdata_ready alone completes a beat
        if (bus.rdata_ready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            ptr_d   = ptr_q + IDX_W'(1);
            beat_d  = beat_q + CNT_W'(1);
            rdata_d = rword;
            rlast_d = ((beat_q + CNT_W'(1)) == RD_LAST);
          end
        end
      end
      WR_BURST: begin
        we = bus.wdata_valid;
        if (bus.wdata_valid) begin
          if (bus.wlast || (beat_q == WR_LAST)) begin
            bresp_d = (bus.wlast && (beat_q == WR_LAST)) ? RESP_OKAY : RESP_SLVERR;
            state_d = WR_RESP;
          end else begin
            ptr_d  = ptr_q + IDX_W'(1);
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      WR_RESP: begin
        if (bus.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_rd) begin
      rdata_d  = rword;
      rvalid_d = 1'b1;
      rlast_d  = (RD_LAST == '0);
      state_d  = RD_BURST;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      bresp_q  <= RESP_OKAY;
`ifdef BURST_MEM_LATENCY_EN
      lat_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      bresp_q  <= bresp_d;
`ifdef BURST_MEM_LATENCY_EN
      lat_q    <= lat_d;
`endif
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.wdata_ready = (state_q == WR_BURST);
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rlast       = rlast_q;
  assign bus.bvalid      = (state_q == WR_RESP);
  assign bus.bresp       = bresp_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: write bursts fill a reference word model,
// read bursts push expected beats that are popped as the responder hands them over.
module tb_burst_mem_responder;
  import popo_mem_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NW  = 128;
  localparam int IW  = $clog2(NW);
  localparam int RL  = 8;
  localparam int WL  = 8;
  localparam int RDL = 4;
`ifdef BURST_MEM_LATENCY_EN
  localparam int LAT = RDL;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  burst_mem_responder_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) bus ();

  burst_mem_responder #(
    .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .NUM_WORDS(NW),
    .READ_BURST_LEN(RL), .WRITE_BURST_LEN(WL), .RD_LATENCY(RDL)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mdl [NW];
  beat_t       rq [$];
  logic [1:0]  bq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [31:0] base,
                          input int wlast_at, input int bdelay);
    int   idx;
    int   n;
    int   to;
    bit   done;
    logic [1:0] e;
    idx  = int'(addr[2 +: IW]);
    n    = 0;
    to   = 0;
    done = 1'b0;
    bq.push_back((wlast_at == WL - 1) ? 2'b00 : 2'b10);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    chk("wr_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    while (!done && to < 100) begin
      to++;
      bus.wdata_valid = 1'b1;
      bus.wdata       = base + n;
      bus.wlast       = (n == wlast_at);
      if (bus.wdata_ready) begin
        @(posedge clk);
        mdl[(idx + n) % NW] = base + n;
        done = (n == wlast_at) || (n == WL - 1);
        n++;
        @(negedge clk);
      end else begin
        step();
      end
    end
    bus.wdata_valid = 1'b0;
    bus.wlast       = 1'b0;
    if (!done) chk("wr_timeout", 32'(n), 32'(WL));
    chk("wready_after_burst", 32'(bus.wdata_ready), 32'd0);
    e = bq.pop_front();
    for (int d = 0; d < bdelay; d++) begin
      chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
      chk("bresp_hold", 32'(bus.bresp), 32'(e));
      step();
    end
    chk("bvalid", 32'(bus.bvalid), 32'd1);
    chk("bresp", 32'(bus.bresp), 32'(e));
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    chk("bvalid_clear", 32'(bus.bvalid), 32'd0);
    chk("req_ready_after_wr", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int stall_at,
                          input int stall_len, input int rst_at);
    int    idx;
    int    beats;
    int    stalls;
    int    cyc;
    int    to;
    bit    held_vld;
    beat_t held;
    beat_t e;
    idx      = int'(addr[2 +: IW]);
    beats    = 0;
    stalls   = 0;
    to       = 0;
    held_vld = 1'b0;
    held     = '0;
    for (int n = 0; n < RL; n++)
      rq.push_back(beat_t'{last: (n == RL - 1), data: mdl[(idx + n) % NW]});
    bus.rdata_ready = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b0;
    bus.req_addr    = addr;
    chk("rd_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    cyc = 1;
    while (!bus.rdata_valid && cyc < 50) begin
      step();
      cyc++;
    end
    chk("first_beat_latency", 32'(cyc), 32'(LAT + 1));
    while (beats < RL && to < 200) begin
      to++;
      if (beats == rst_at) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_rvalid", 32'(bus.rdata_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        rq.delete();
        return;
      end
      if (beats == stall_at && stalls < stall_len) begin
        bus.rdata_ready = 1'b0;
        stalls++;
      end else begin
        bus.rdata_ready = 1'b1;
      end
      if (held_vld) begin
        chk("hold_valid", 32'(bus.rdata_valid), 32'd1);
        chk("hold_data", bus.rdata, held.data);
        chk("hold_last", 32'(bus.rlast), 32'(held.last));
      end
      held_vld = bus.rdata_valid && !bus.rdata_ready;
      held     = beat_t'{last: bus.rlast, data: bus.rdata};
      if (bus.rdata_valid && bus.rdata_ready) begin
        if (rq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = rq.pop_front();
          chk("rdata", bus.rdata, e.data);
          chk("rlast", 32'(bus.rlast), 32'(e.last));
        end
        beats++;
      end
      step();
    end
    bus.rdata_ready = 1'b1;
    if (beats < RL) chk("rd_timeout", 32'(beats), 32'(RL));
    chk("rvalid_after_burst", 32'(bus.rdata_valid), 32'd0);
    chk("req_ready_after_rd", 32'(bus.req_ready), 32'd1);
    rq.delete();
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.wlast       = 1'b0;
    bus.rdata_ready = 1'b1;
    bus.bready      = 1'b0;
    rst_n           = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_wready", 32'(bus.wdata_ready), 32'd0);
    chk("reset_rvalid", 32'(bus.rdata_valid), 32'd0);
    chk("reset_rlast", 32'(bus.rlast), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_bvalid", 32'(bus.bvalid), 32'd0);
    chk("reset_bresp", 32'(bus.bresp), 32'd0);
    rst_n = 1'b1;
    step();

    // preload words 8..15 then read them back
    wr_burst(32'h20, 32'h100, WL - 1, 0);
    rd_burst(32'h20, -1, 0, -1);
    wr_burst(32'h40, 32'hA0, WL - 1, 0);
    rd_burst(32'h40, -1, 0, -1);
    // unaligned low address bits select the same word
    rd_burst(32'h43, -1, 0, -1);
    // bursts wrapping past the top word
    wr_burst(32'h1F0, 32'hC0, WL - 1, 0);
    rd_burst(32'h1F0, -1, 0, -1);
    // early wlast: only 4 words change, SLVERR with delayed bready
    wr_burst(32'h0, 32'h50, WL - 1, 0);
    wr_burst(32'h0, 32'hB0, 3, 2);
    rd_burst(32'h0, -1, 0, -1);
    // missing wlast ends at full length with SLVERR
    wr_burst(32'h60, 32'hE0, -1, 1);
    rd_burst(32'h60, -1, 0, -1);
    // consumer stall mid-burst
    rd_burst(32'h40, 3, 3, -1);
    rd_burst(32'h20, 0, 2, -1);
    // reset during beat 4, then a fresh read
    rd_burst(32'h20, -1, 0, 4);
    rd_burst(32'h20, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "bench timeout");
  end
endmodule
